// File: rtl/seg7_capture.sv
// Seven-segment display capture: debounces a sampled segment pattern, decodes
// each newly accepted digit and queues {err, digit} in a first-word fall-through FIFO.
module seg7_capture #(
  parameter int STABLE_CYCLES = 4,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_in,
  input  logic       enable,
  input  logic       rd_en,
  output logic [4:0] rd_data,
  output logic       valid,
  output logic       full,
  output logic       overflow,
  output logic [3:0] cur_digit,
  output logic       cur_err,
  output logic [7:0] change_count
);

  localparam int         AW   = $clog2(FIFO_DEPTH);
  localparam logic [3:0] LAST = 4'(STABLE_CYCLES - 1);
  localparam logic [AW:0] ONE   = (AW + 1)'(1);
  localparam logic [AW:0] DEPTH = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SETTLE, STABLE} state_t;

  state_t      state;
  logic [6:0]  sample_q;
  logic [6:0]  candidate;
  logic [6:0]  accepted;
  logic [3:0]  cnt;
  logic        commit;
  logic [4:0]  entry;
  logic        pop;
  logic        wr_ok;
  logic [4:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  // Unknown non-blank patterns report err with digit 0.
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'h3F: decode = 5'h00;
      7'h06: decode = 5'h01;
      7'h5B: decode = 5'h02;
      7'h4F: decode = 5'h03;
      7'h66: decode = 5'h04;
      7'h6D: decode = 5'h05;
      7'h7D: decode = 5'h06;
      7'h07: decode = 5'h07;
      7'h7F: decode = 5'h08;
      7'h6F: decode = 5'h09;
      7'h77: decode = 5'h0A;
      7'h7C: decode = 5'h0B;
      7'h39: decode = 5'h0C;
      7'h5E: decode = 5'h0D;
      7'h79: decode = 5'h0E;
      7'h71: decode = 5'h0F;
      default: decode = 5'h10;
    endcase
  endfunction

  always_ff @(posedge clk) sample_q <= seg_in;

  always_comb begin
    entry  = decode(candidate);
    commit = !rst && enable && (state == SETTLE) && (sample_q == candidate) &&
             !(cnt < LAST) && (candidate != 7'h00) && (candidate != accepted);
    valid  = (count != '0);
    full   = (count == DEPTH);
    pop    = rd_en && valid;
    wr_ok  = commit && (!full || pop);
    rd_data = valid ? mem[rd_ptr] : 5'b00000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      candidate    <= '0;
      accepted     <= '0;
      cur_digit    <= '0;
      cur_err      <= 1'b0;
      change_count <= '0;
    end else if (!enable) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          state     <= SETTLE;
          candidate <= sample_q;
          cnt       <= '0;
        end
        SETTLE: begin
          if (sample_q != candidate) begin
            candidate <= sample_q;
            cnt       <= '0;
          end else if (cnt < LAST) begin
            cnt <= cnt + 4'd1;
          end else begin
            state <= STABLE;
            if (commit) begin
              accepted             <= candidate;
              {cur_err, cur_digit} <= entry;
              if (change_count != 8'hFF) change_count <= change_count + 8'd1;
            end
          end
        end
        STABLE: begin
          if (sample_q != candidate) begin
            state     <= SETTLE;
            candidate <= sample_q;
            cnt       <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A commit into a full FIFO only lands when the same edge frees a slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, pop})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
      if (commit && !wr_ok) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= entry;
  end

endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture: a run-length reference model is compared every
// cycle, plus literal expectations for the documented scenarios.
module tb_seg7_capture;

  localparam int STABLE_CYCLES = 4;
  localparam int FIFO_DEPTH    = 8;
  localparam logic [6:0] SEGTBL [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                         7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] seg_in = 7'h00;
  logic       enable = 1'b0;
  logic       rd_en = 1'b0;
  logic [4:0] rd_data;
  logic       valid, full, overflow, cur_err;
  logic [3:0] cur_digit;
  logic [7:0] change_count;

  int checks = 0;
  int errors = 0;

  seg7_capture #(.STABLE_CYCLES(STABLE_CYCLES), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .enable(enable), .rd_en(rd_en),
    .rd_data(rd_data), .valid(valid), .full(full), .overflow(overflow),
    .cur_digit(cur_digit), .cur_err(cur_err), .change_count(change_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [6:0] s, input logic en,
                               input logic rd, input int n);
    rst    = r;
    seg_in = s;
    enable = en;
    rd_en  = rd;
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [4:0] refDecode(input logic [6:0] p);
    for (int i = 0; i < 16; i++)
      if (SEGTBL[i] == p) return {1'b0, 4'(i)};
    return 5'b10000;
  endfunction

  // Reference: a pattern commits on the edge where it has been observed, with
  // enable high, for exactly STABLE_CYCLES+1 consecutive edges.
  logic [4:0] mq[$];
  int         run = 0;
  int         m_cc = 0;
  logic [6:0] last_obs = 7'h00, prev_seg = 7'h00, m_acc = 7'h00, m_obs;
  logic [4:0] m_cur = 5'b0;
  logic       m_ovf = 1'b0, m_pop, m_commit;

  always begin
    @(posedge clk);
    m_obs    = prev_seg;
    prev_seg = seg_in;
    if (rst) begin
      run = 0; m_cc = 0; m_acc = 7'h00; m_cur = 5'b0; m_ovf = 1'b0;
      mq.delete();
    end else begin
      m_pop = rd_en && (mq.size() > 0);
      if (!enable) run = 0;
      else if (run > 0 && m_obs == last_obs) run = (run < 1000) ? run + 1 : run;
      else run = 1;
      last_obs = m_obs;
      m_commit = (run == STABLE_CYCLES + 1) && (m_obs != 7'h00) && (m_obs != m_acc);
      if (m_pop) void'(mq.pop_front());
      if (m_commit) begin
        m_acc = m_obs;
        m_cur = refDecode(m_obs);
        if (m_cc < 255) m_cc++;
        if (mq.size() < FIFO_DEPTH) mq.push_back(m_cur);
        else m_ovf = 1'b1;
      end
    end
    #1;
    checkOutput("m_valid", {7'b0, valid}, {7'b0, mq.size() > 0});
    checkOutput("m_full", {7'b0, full}, {7'b0, mq.size() == FIFO_DEPTH});
    checkOutput("m_overflow", {7'b0, overflow}, {7'b0, m_ovf});
    checkOutput("m_rd_data", {3'b0, rd_data}, {3'b0, (mq.size() > 0) ? mq[0] : 5'b0});
    checkOutput("m_cur_digit", {4'b0, cur_digit}, {4'b0, m_cur[3:0]});
    checkOutput("m_cur_err", {7'b0, cur_err}, {7'b0, m_cur[4]});
    checkOutput("m_change_count", change_count, 8'(m_cc));
  end

  logic [6:0] digs [9] = '{7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  logic [4:0] order1 [8] = '{5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h08, 5'h0A};

  initial begin
    applyStimulus(1, 7'h00, 0, 0, 2);
    checkOutput("rst_valid", {7'b0, valid}, 8'h00);
    checkOutput("rst_count", change_count, 8'h00);
    checkOutput("rst_rd_data", {3'b0, rd_data}, 8'h00);

    // Single digit with latency boundary
    applyStimulus(0, 7'h5B, 1, 0, 5);
    checkOutput("lat_edge5_valid", {7'b0, valid}, 8'h00);
    applyStimulus(0, 7'h5B, 1, 0, 1);
    checkOutput("lat_edge6_valid", {7'b0, valid}, 8'h01);
    applyStimulus(0, 7'h5B, 1, 0, 4);
    checkOutput("d2_rd_data", {3'b0, rd_data}, 8'h02);
    checkOutput("d2_cur_digit", {4'b0, cur_digit}, 8'h02);
    checkOutput("d2_count", change_count, 8'h01);
    applyStimulus(0, 7'h5B, 1, 1, 1);
    checkOutput("d2_popped", {7'b0, valid}, 8'h00);

    // Short 06 burst is rejected
    applyStimulus(0, 7'h06, 1, 0, 3);
    applyStimulus(0, 7'h4F, 1, 0, 10);
    checkOutput("glitch_rd_data", {3'b0, rd_data}, 8'h03);
    checkOutput("glitch_count", change_count, 8'h02);
    applyStimulus(0, 7'h4F, 1, 1, 1);
    checkOutput("glitch_one_entry", {7'b0, valid}, 8'h00);

    // Blank neither commits nor changes the accepted pattern
    applyStimulus(0, 7'h3F, 1, 0, 10);
    applyStimulus(0, 7'h00, 1, 0, 10);
    applyStimulus(0, 7'h3F, 1, 0, 10);
    checkOutput("blank_count", change_count, 8'h03);
    checkOutput("blank_cur_digit", {4'b0, cur_digit}, 8'h00);
    applyStimulus(0, 7'h3F, 1, 1, 1);
    checkOutput("blank_one_entry", {7'b0, valid}, 8'h00);

    applyStimulus(0, 7'h12, 1, 0, 10);
    checkOutput("err_rd_data", {3'b0, rd_data}, 8'h10);
    checkOutput("err_cur_err", {7'b0, cur_err}, 8'h01);
    applyStimulus(0, 7'h12, 1, 1, 1);

    // Fill, then pop and write on the same edge while full
    applyStimulus(1, 7'h00, 0, 0, 1);
    for (int i = 0; i < 8; i++) applyStimulus(0, digs[i], 1, 0, 8);
    checkOutput("fill_full", {7'b0, full}, 8'h01);
    applyStimulus(0, 7'h77, 1, 0, 5);
    applyStimulus(0, 7'h77, 1, 1, 1);
    checkOutput("popwr_full", {7'b0, full}, 8'h01);
    checkOutput("popwr_overflow", {7'b0, overflow}, 8'h00);
    checkOutput("popwr_head", {3'b0, rd_data}, 8'h02);
    applyStimulus(0, 7'h6F, 1, 0, 8);
    checkOutput("drop_overflow", {7'b0, overflow}, 8'h01);
    checkOutput("drop_count", change_count, 8'h0A);
    for (int i = 0; i < 8; i++) begin
      checkOutput("wrap_order", {3'b0, rd_data}, {3'b0, order1[i]});
      applyStimulus(0, 7'h6F, 1, 1, 1);
    end
    checkOutput("drained", {7'b0, valid}, 8'h00);
    applyStimulus(0, 7'h7C, 1, 0, 5);
    applyStimulus(0, 7'h7C, 1, 1, 1);
    checkOutput("empty_popwr_valid", {7'b0, valid}, 8'h01);
    checkOutput("empty_popwr_data", {3'b0, rd_data}, 8'h0B);
    applyStimulus(0, 7'h7C, 1, 1, 1);

    // Nine distinct digits into an eight-entry FIFO
    applyStimulus(1, 7'h00, 0, 0, 1);
    for (int i = 0; i < 9; i++) applyStimulus(0, digs[i], 1, 0, 8);
    checkOutput("nine_full", {7'b0, full}, 8'h01);
    checkOutput("nine_overflow", {7'b0, overflow}, 8'h01);
    checkOutput("nine_count", change_count, 8'h09);
    for (int i = 0; i < 8; i++) begin
      checkOutput("nine_order", {3'b0, rd_data}, 8'(i + 1));
      applyStimulus(0, 7'h6F, 1, 1, 1);
    end

    // Reset in the middle of settling 7F
    applyStimulus(0, 7'h7F, 1, 0, 3);
    applyStimulus(1, 7'h7F, 1, 1, 1);
    checkOutput("mid_rst_valid", {7'b0, valid}, 8'h00);
    checkOutput("mid_rst_overflow", {7'b0, overflow}, 8'h00);
    checkOutput("mid_rst_count", change_count, 8'h00);
    checkOutput("mid_rst_digit", {4'b0, cur_digit}, 8'h00);
    applyStimulus(0, 7'h00, 1, 0, 10);
    checkOutput("no_7f_entry", {7'b0, valid}, 8'h00);
    applyStimulus(0, 7'h66, 1, 0, 8);
    checkOutput("after_rst_data", {3'b0, rd_data}, 8'h04);

    // Enable low holds idle; S-edge hold rejected, S+1-edge hold accepted
    applyStimulus(0, 7'h6D, 0, 0, 10);
    checkOutput("disabled_count", change_count, 8'h01);
    applyStimulus(0, 7'h6D, 1, 0, 8);
    checkOutput("enabled_digit", {4'b0, cur_digit}, 8'h05);
    applyStimulus(0, 7'h07, 1, 0, 4);
    applyStimulus(0, 7'h6D, 1, 0, 8);
    checkOutput("hold4_count", change_count, 8'h02);
    applyStimulus(0, 7'h07, 1, 0, 5);
    applyStimulus(0, 7'h6D, 1, 0, 8);
    checkOutput("hold5_count", change_count, 8'h04);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_capture.md
SEG7_CAPTURE -- requirements
Module: seg7_capture

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, is the number of consecutive equal samples needed to accept a segment pattern; legal range 2..15.
REQ-002 Parameter FIFO_DEPTH, default 8, is the capture FIFO depth; it shall be a power of two, 2..16.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  synchronous reset, active-high.
REQ-005 seg_in  in  7  segment pattern {g,f,e,d,c,b,a}, active-high, same clock domain as clk.
REQ-006 enable  in  1  capture enable; low holds the block idle.
REQ-007 rd_en  in  1  pops the FIFO head at the clock edge when valid=1.
REQ-008 rd_data  out  5  FIFO head {err, digit[3:0]}, first-word fall-through.
REQ-009 valid  out  1  FIFO not empty.
REQ-010 full  out  1  FIFO holds FIFO_DEPTH entries.
REQ-011 overflow  out  1  sticky flag: a commit was dropped because the FIFO was full.
REQ-012 cur_digit  out  4  digit of the currently accepted pattern.
REQ-013 cur_err  out  1  currently accepted pattern is not in the decode table.
REQ-014 change_count  out  8  number of commits, saturating at 255.

Function
REQ-015 Decode table (hex pattern->digit): 3F->0, 06->1, 5B->2, 4F->3, 66->4, 6D->5, 7D->6, 07->7, 7F->8, 6F->9, 77->A, 7C->B, 39->C, 5E->D, 79->E, 71->F.
REQ-016 Any other pattern except 00 shall decode to err=1 with digit=0; pattern 00 (blank) shall never be committed and shall leave the accepted pattern unchanged.
REQ-017 seg_in shall be registered into sample_q every edge, regardless of enable.
REQ-018 The FSM shall have exactly three states: IDLE, SETTLE and STABLE.
REQ-019 IDLE: no commits; when enable=1, go to SETTLE with candidate=sample_q and cnt=0.
REQ-020 SETTLE: if sample_q!=candidate, set candidate=sample_q and cnt=0.
REQ-021 SETTLE: else if cnt<STABLE_CYCLES-1, increment cnt.
REQ-022 SETTLE: else go to STABLE and commit candidate, unless it equals the accepted pattern or is blank.
REQ-023 STABLE: if sample_q!=candidate, go to SETTLE with candidate=sample_q and cnt=0; otherwise hold.
REQ-024 From any state, enable=0 shall force IDLE at the next edge; the accepted pattern and the FIFO are retained.
REQ-025 Commit, done in one edge, shall: update the accepted pattern, cur_digit and cur_err; write {err,digit} to the FIFO; and increment change_count (saturating).
REQ-026 Latency: a non-blank new pattern held on seg_in, with enable=1 and the FSM in STABLE, shall set valid after the (STABLE_CYCLES+2)th rising edge after seg_in changes (edge 6 at the default).
REQ-027 A pattern held for fewer than STABLE_CYCLES+1 edges shall never be committed (glitch rejection).
REQ-028 Write when full with no pop: the entry is dropped, overflow is set, and change_count still increments.
REQ-029 Simultaneous pop and write when full: both succeed, full stays 1, overflow is unchanged.
REQ-030 Simultaneous pop and write when empty: the write succeeds, the pop is ignored, and valid=1 after the edge.
REQ-031 rd_en with valid=0 shall be ignored.
REQ-032 FIFO pointers shall wrap modulo FIFO_DEPTH; entries shall come out in commit order.
REQ-033 rd_data shall read 5'b00000 when valid=0.

Reset
REQ-034 On rst=1 at an edge: state=IDLE, cnt=0, candidate=00, accepted pattern=00, FIFO empty.
REQ-035 On the same edge, all outputs shall reset: valid=0, full=0, overflow=0, cur_digit=0, cur_err=0, change_count=0, rd_data=0.
REQ-036 rst shall override enable, rd_en and any in-progress commit on the same edge.
REQ-037 Reset mid-SETTLE shall discard the candidate; a subsequent capture starts from IDLE.

Verification
REQ-038 enable=1, seg_in=5B held for 10 edges -> valid=1 after edge 6; rd_data=00010; cur_digit=2; change_count=1.
REQ-039 seg_in=06 for 3 edges, then 4F held -> only 4F is committed (rd_data=00011); 06 is never pushed.
REQ-040 Commit 3F, then 00 for 10 edges, then 3F again -> one FIFO entry only; cur_digit stays 0.
REQ-041 seg_in=12 held -> entry 10000; cur_err=1.
REQ-042 Nine distinct digits (FIFO_DEPTH=8) with no reads -> full=1, overflow=1, change_count=9; reads return the first eight in order.
REQ-043 rst asserted during SETTLE after pattern 7F -> all outputs zero at the next edge; no entry for 7F.
